dffre_bist_seq: RTL and testbench

Synthesizable stimulus-and-check sequencer for the enable/reset D-flip-flop equivalence flow. It drives the reset, enable and data inputs shared by a golden DFF and a post-route netlist DFF, then samples both Q outputs and counts mismatches. The run is a fixed directed phase followed by an LFSR-driven random phase. It sits on the far side of the DUT pair and lets the same check run on silicon or in emulation without a behavioural bench.

---
 rtl/dffre_bist_pkg.sv | 39 +++
 rtl/dffre_bist_lfsr.sv | 40 ++++
 rtl/dffre_bist_seq.sv | 161 ++++++++++++++++
 tb/tb_dffre_bist_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dffre_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dffre_bist_pkg
//  Description : Shared constants for the enable/reset DFF equivalence
//                sequencer: FSM state encoding, the directed stimulus table
//                and the Galois LFSR tap mask with its step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package dffre_bist_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_DRIVE   = 3'd1;
    localparam state_t c_ST_SETTLE  = 3'd2;
    localparam state_t c_ST_COMPARE = 3'd3;
    localparam state_t c_ST_DRAIN   = 3'd4;
    localparam state_t c_ST_DONE    = 3'd5;

    // Directed phase: each entry is {reset, enable, d}; entry 0 is rightmost.
    localparam int c_DIR_STEPS = 6;
    localparam logic [c_DIR_STEPS-1:0][2:0] c_DIR_VEC = {
        3'b011,   // step 5
        3'b001,   // step 4
        3'b010,   // step 3
        3'b011,   // step 2
        3'b001,   // step 1
        3'b101    // step 0
    };

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? c_LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffre_bist_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : dffre_bist_lfsr
//  Description : 16-bit Galois LFSR with synchronous load and advance enables.
//                Load has priority over advance.
//  Ports       : clk     - rising-edge clock
//                rst     - asynchronous active-high reset (state <= SEED)
//                i_load  - reload SEED
//                i_adv   - step the register once
//                o_bit   - current LSB (random data bit)
//  Revision    : 1.0 - initial release
// ============================================================================
module dffre_bist_lfsr
    import dffre_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_adv,
    output logic o_bit
);

    logic [15:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_bit = r_state[0];

endmodule
`default_nettype wire

// File: rtl/dffre_bist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dffre_bist_seq
//  Description : Stimulus-and-check sequencer for a golden / netlist DFF pair.
//                Drives reset, enable and data to both DUTs (directed steps
//                then LFSR random steps), samples both Q outputs once per
//                step and keeps a saturating mismatch count.
//  Ports       : clk               - rising-edge clock
//                i_Reset           - asynchronous active-high reset
//                i_Start           - start pulse, honoured in IDLE/DONE only
//                i_Q_Golden        - golden DFF output
//                i_Q_Netlist       - netlist DFF output
//                o_Dut_Reset/Enable/D - stimulus to both DUTs
//                o_Busy            - run in progress (DRIVE .. DRAIN)
//                o_Done            - run finished (level)
//                o_Pass            - no mismatches, valid with o_Done
//                o_Mismatch_Count  - saturating compare-failure count
//  Revision    : 1.0 - initial release
// ============================================================================
module dffre_bist_seq
    import dffre_bist_pkg::*;
#(
    parameter int          N_RANDOM      = 1000,
    parameter int          SETTLE_CYCLES = 2,      // >= 1
    parameter int          DRAIN_CYCLES  = 5,      // >= 1
    parameter int          CNT_W         = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1 // non-zero
) (
    input  logic             clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic             i_Q_Golden,
    input  logic             i_Q_Netlist,
    output logic             o_Dut_Reset,
    output logic             o_Dut_Enable,
    output logic             o_Dut_D,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [CNT_W-1:0] o_Mismatch_Count
);

    localparam int c_LAST_STEP = c_DIR_STEPS + N_RANDOM - 1;
    localparam int c_STEP_W    = $clog2(c_LAST_STEP + 1);
    localparam int c_TMR_MAX   = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int c_TMR_W     = $clog2(c_TMR_MAX + 1);

    state_t              r_state;
    logic [c_STEP_W-1:0] r_step;
    logic [c_TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]    r_count;
    logic [2:0]          r_stim;      // {reset, enable, d}
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic                w_start_ok;
    logic                w_last;
    logic [c_STEP_W-1:0] w_step_nxt;
    logic                w_nxt_directed;
    logic [2:0]          w_next_stim;
    logic                w_lfsr_bit;
    logic                w_lfsr_adv;
    logic                w_mis;

    always_comb begin
        w_start_ok     = i_Start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_last         = (r_step == c_STEP_W'(c_LAST_STEP));
        w_step_nxt     = r_step + 1'b1;
        w_nxt_directed = (w_step_nxt < c_STEP_W'(c_DIR_STEPS));
        w_next_stim    = w_nxt_directed ? c_DIR_VEC[w_step_nxt[2:0]] : {1'b0, 1'b1, w_lfsr_bit};
        // The LFSR steps on the same edge that consumes its bit for a random step.
        w_lfsr_adv     = (r_state == c_ST_COMPARE) && !w_last && !w_nxt_directed;
        w_mis          = i_Q_Golden ^ i_Q_Netlist;
    end

    dffre_bist_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (i_Reset),
        .i_load (w_start_ok),
        .i_adv  (w_lfsr_adv),
        .o_bit  (w_lfsr_bit)
    );

    // Stimulus is registered on the edge that enters DRIVE, so the DUTs see it
    // for the whole DRIVE cycle and capture it on the DRIVE->next edge.
    always_ff @(posedge clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= c_ST_IDLE;
            r_step  <= '0;
            r_timer <= '0;
            r_count <= '0;
            r_stim  <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (i_Start) begin
                        r_state <= c_ST_DRIVE;
                        r_step  <= '0;
                        r_timer <= '0;
                        r_count <= '0;
                        r_stim  <= c_DIR_VEC[0];
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                c_ST_DRIVE: begin
                    r_timer <= '0;
                    r_state <= (SETTLE_CYCLES > 1) ? c_ST_SETTLE : c_ST_COMPARE;
                end
                c_ST_SETTLE: begin
                    if (r_timer == c_TMR_W'(SETTLE_CYCLES - 2)) begin
                        r_state <= c_ST_COMPARE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ST_COMPARE: begin
                    if (w_mis && (r_count != {CNT_W{1'b1}})) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_last) begin
                        r_timer <= '0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_step  <= w_step_nxt;
                        r_stim  <= w_next_stim;
                        r_state <= c_ST_DRIVE;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_timer == c_TMR_W'(DRAIN_CYCLES - 1)) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_count == '0);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_Dut_Reset      = r_stim[2];
    assign o_Dut_Enable     = r_stim[1];
    assign o_Dut_D          = r_stim[0];
    assign o_Busy           = r_busy;
    assign o_Done           = r_done;
    assign o_Pass           = r_pass;
    assign o_Mismatch_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dffre_bist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dffre_bist_seq
//  Description : Self-checking bench for dffre_bist_seq (N_RANDOM=8,
//                SETTLE_CYCLES=2, DRAIN_CYCLES=5). A second instance with a
//                3-bit counter sees a permanent mismatch to show saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dffre_bist_seq;

    localparam int N_RAND  = 8;
    localparam int N_STEPS = 6 + N_RAND;
    localparam int STEP_CY = 3;                 // SETTLE_CYCLES + 1
    localparam int DONE_AT = N_STEPS * STEP_CY + 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        q_gold = 1'b0;
    logic        inj = 1'b0;
    logic        q_net;
    logic        dut_rst, dut_en, dut_d, busy, done, pass;
    logic [15:0] cnt;
    logic        d2_rst, d2_en, d2_d, busy2, done2, pass2;
    logic [2:0]  cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign q_net = q_gold ^ inj;

    // Behavioural golden DFF driven by the sequencer's stimulus
    always @(posedge clk) begin
        if (dut_rst)     q_gold <= 1'b0;
        else if (dut_en) q_gold <= dut_d;
    end

    dffre_bist_seq #(
        .N_RANDOM(N_RAND), .SETTLE_CYCLES(2), .DRAIN_CYCLES(5), .CNT_W(16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .i_Reset(rst), .i_Start(start),
        .i_Q_Golden(q_gold), .i_Q_Netlist(q_net),
        .o_Dut_Reset(dut_rst), .o_Dut_Enable(dut_en), .o_Dut_D(dut_d),
        .o_Busy(busy), .o_Done(done), .o_Pass(pass), .o_Mismatch_Count(cnt)
    );

    dffre_bist_seq #(
        .N_RANDOM(N_RAND), .SETTLE_CYCLES(2), .DRAIN_CYCLES(5), .CNT_W(3), .LFSR_SEED(16'hACE1)
    ) dut_sat (
        .clk(clk), .i_Reset(rst), .i_Start(start),
        .i_Q_Golden(1'b0), .i_Q_Netlist(1'b1),
        .o_Dut_Reset(d2_rst), .o_Dut_Enable(d2_en), .o_Dut_D(d2_d),
        .o_Busy(busy2), .o_Done(done2), .o_Pass(pass2), .o_Mismatch_Count(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Directed table as {reset, enable, d}
    function automatic logic [2:0] dir_vec(input int k);
        case (k)
            0: return 3'b101;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

    // Injection modes: 0 none, 1 always, 2 step-3 COMPARE only,
    // 3 random each cycle, 4 step-3 SETTLE only.
    task automatic do_run(input int mode, input bit pulse_busy, input int exp_fixed,
                          input int exp_pass, input bit chk_sat);
        int          cyc;
        int          exp_cnt;
        int          k;
        bit          got_done;
        logic [15:0] lf;
        logic [2:0]  stim;
        lf      = 16'hACE1;
        exp_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_clear_on_start", done, 0);
        chk("count_clear_on_start", cnt, 0);
        cyc = 0;
        got_done = 0;
        while (!got_done && cyc < 200) begin
            if ((cyc % STEP_CY) == 0 && (cyc / STEP_CY) < N_STEPS) begin
                k = cyc / STEP_CY;
                if (k < 6) begin
                    stim = dir_vec(k);
                end else begin
                    stim = {1'b0, 1'b1, lf[0]};
                    lf   = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
                end
                chk($sformatf("stim_step%0d", k), {29'd0, dut_rst, dut_en, dut_d}, {29'd0, stim});
            end
            case (mode)
                1:       inj = 1'b1;
                2:       inj = (cyc == 3 * STEP_CY + 2);
                3:       inj = 1'($urandom_range(0, 1));
                4:       inj = (cyc == 3 * STEP_CY + 1);
                default: inj = 1'b0;
            endcase
            if ((cyc % STEP_CY) == 2 && cyc < N_STEPS * STEP_CY && inj) exp_cnt++;
            if (pulse_busy && cyc == 20) start = 1'b1;
            if (cyc == 21) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (done) got_done = 1;
        end
        inj   = 1'b0;
        start = 1'b0;
        if (exp_fixed >= 0) exp_cnt = exp_fixed;
        if (exp_pass < 0) exp_pass = (exp_cnt == 0) ? 1 : 0;
        chk("done_latency", cyc, DONE_AT);
        chk("busy_fall", busy, 0);
        chk("mismatch_count", cnt, exp_cnt);
        chk("pass", pass, exp_pass);
        if (chk_sat) begin
            chk("sat_count", cnt2, 7);
            chk("sat_pass", pass2, 0);
            chk("sat_done", done2, 1);
        end
    endtask

    typedef struct {
        int mode;
        bit pulse_busy;
        int exp_count;   // -1: from the bench model
        int exp_pass;    // -1: derived from expected count
    } run_t;

    run_t runs [6];

    initial begin
        int cyc;
        runs[0] = '{0, 1'b0, 0, 1};
        runs[1] = '{1, 1'b0, 14, 0};
        runs[2] = '{2, 1'b0, 1, 0};
        runs[3] = '{4, 1'b0, 0, 1};
        runs[4] = '{3, 1'b1, -1, -1};
        runs[5] = '{0, 1'b1, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {25'd0, dut_rst, dut_en, dut_d, busy, done, pass, cnt2[0]},
            32'd0);
        chk("rst_count", cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", busy, 0);

        for (int i = 0; i < 6; i++) begin
            do_run(runs[i].mode, runs[i].pulse_busy, runs[i].exp_count, runs[i].exp_pass, i == 0);
        end

        // Asynchronous reset during step 4 SETTLE, after 4 forced mismatches
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inj   = 1'b1;
        cyc   = 0;
        while (cyc < 4 * STEP_CY + 1) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_count", cnt, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_stim", {29'd0, dut_rst, dut_en, dut_d}, 0);
        chk("async_rst_flags", {29'd0, busy, done, pass}, 0);
        chk("async_rst_count", cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        inj = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", {30'd0, busy, done}, 0);
        do_run(0, 1'b0, 0, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
